// File: rtl/jelly_fixed_to_float.sv
// Pipelined signed fixed-point to float converter.
// Four register stages: abs value, leading-one search, normalise, pack.
// All stages advance together when the output slot is free and cke is high.
module jelly_fixed_to_float #(
  parameter int USER_WIDTH         = 0,
  parameter int S_FIXED_INT_WIDTH  = 16,
  parameter int S_FIXED_FRAC_WIDTH = 8,
  parameter int M_FLOAT_EXP_WIDTH  = 6,
  parameter int M_FLOAT_EXP_OFFSET = (1 << (M_FLOAT_EXP_WIDTH - 1)) - 1,
  parameter int M_FLOAT_FRAC_WIDTH = 16,
  localparam int USER_BITS         = (USER_WIDTH > 0) ? USER_WIDTH : 1,
  localparam int S_FIXED_WIDTH     = S_FIXED_INT_WIDTH + S_FIXED_FRAC_WIDTH,
  localparam int M_FLOAT_WIDTH     = 1 + M_FLOAT_EXP_WIDTH + M_FLOAT_FRAC_WIDTH
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic                     cke,
  input  logic [USER_BITS-1:0]     s_user,
  input  logic [S_FIXED_WIDTH-1:0] s_fixed,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [USER_BITS-1:0]     m_user,
  output logic [M_FLOAT_WIDTH-1:0] m_float,
  output logic                     m_valid,
  input  logic                     m_ready
);

  localparam int POS_WIDTH = $clog2(S_FIXED_WIDTH);
  localparam int EXP_MAX   = (1 << M_FLOAT_EXP_WIDTH) - 1;
  localparam int CAT_WIDTH = S_FIXED_WIDTH + M_FLOAT_FRAC_WIDTH;

  logic                     w_adv;

  // valid/user travel alongside the data through all four stages
  logic [3:0]               r_valid;
  logic [USER_BITS-1:0]     r_user [0:3];

  logic                     r0_sign;
  logic [S_FIXED_WIDTH-1:0] r0_mag;

  logic                     r1_sign;
  logic                     r1_zero;
  logic [POS_WIDTH-1:0]     r1_pos;
  logic [S_FIXED_WIDTH-1:0] r1_mag;

  logic                     r2_sign;
  logic                     r2_zero;
  logic signed [31:0]       r2_exp;
  logic [M_FLOAT_FRAC_WIDTH-1:0] r2_frac;

  logic [M_FLOAT_WIDTH-1:0] r3_float;

  logic [S_FIXED_WIDTH-1:0] w_abs;
  logic [POS_WIDTH-1:0]     w_pos;
  logic                     w_zero;
  logic [S_FIXED_WIDTH-1:0] w_shift;
  logic [CAT_WIDTH-1:0]     w_cat;
  logic [M_FLOAT_FRAC_WIDTH-1:0] w_frac;
  logic signed [31:0]       w_exp;
  logic [M_FLOAT_WIDTH-1:0] w_float;

  // the whole pipe moves only when the output register can be overwritten
  assign w_adv   = cke & (~r_valid[3] | m_ready);
  assign s_ready = w_adv;
  assign m_valid = r_valid[3];
  assign m_user  = r_user[3];
  assign m_float = r3_float;

  // magnitude; the most negative input wraps to 2^(W-1), which is correct unsigned
  always_comb begin
    w_abs = s_fixed;
    if (s_fixed[S_FIXED_WIDTH-1]) begin
      w_abs = (~s_fixed) + S_FIXED_WIDTH'(1);
    end
  end

  // leading-one position of the stage-0 magnitude (highest set bit wins)
  always_comb begin
    w_pos  = '0;
    w_zero = (r0_mag == '0);
    for (int i = 0; i < S_FIXED_WIDTH; i++) begin
      if (r0_mag[i]) begin
        w_pos = POS_WIDTH'(i);
      end
    end
  end

  // normalise: shift the leading one out of the top so the bits below it are
  // MSB-aligned, then take the top FRAC bits (zero-padded or truncated)
  always_comb begin
    w_shift = r1_mag << (S_FIXED_WIDTH - int'(r1_pos));
    w_cat   = {w_shift, {M_FLOAT_FRAC_WIDTH{1'b0}}};
    w_frac  = M_FLOAT_FRAC_WIDTH'(w_cat >> S_FIXED_WIDTH);
    w_exp   = int'(r1_pos) - S_FIXED_FRAC_WIDTH + M_FLOAT_EXP_OFFSET;
  end

  // pack with saturation on overflow and flush-to-zero on underflow
  always_comb begin
    w_float = {r2_sign, r2_exp[M_FLOAT_EXP_WIDTH-1:0], r2_frac};
    if (r2_zero || (r2_exp < 0)) begin
      w_float = '0;
    end else if (r2_exp > EXP_MAX) begin
      w_float = {r2_sign, {M_FLOAT_EXP_WIDTH{1'b1}}, {M_FLOAT_FRAC_WIDTH{1'b1}}};
    end
  end

  // valid and sideband shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < 4; i++) begin
        r_user[i] <= '0;
      end
    end else if (w_adv) begin
      r_valid   <= {r_valid[2:0], s_valid};
      r_user[0] <= s_user;
      for (int i = 1; i < 4; i++) begin
        r_user[i] <= r_user[i-1];
      end
    end
  end

  // data stages 0..3
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_sign  <= 1'b0;
      r0_mag   <= '0;
      r1_sign  <= 1'b0;
      r1_zero  <= 1'b0;
      r1_pos   <= '0;
      r1_mag   <= '0;
      r2_sign  <= 1'b0;
      r2_zero  <= 1'b0;
      r2_exp   <= '0;
      r2_frac  <= '0;
      r3_float <= '0;
    end else if (w_adv) begin
      r0_sign  <= s_fixed[S_FIXED_WIDTH-1];
      r0_mag   <= w_abs;
      r1_sign  <= r0_sign;
      r1_zero  <= w_zero;
      r1_pos   <= w_pos;
      r1_mag   <= r0_mag;
      r2_sign  <= r1_sign;
      r2_zero  <= r1_zero;
      r2_exp   <= w_exp;
      r2_frac  <= w_frac;
      r3_float <= w_float;
    end
  end

endmodule

// File: tb/tb_jelly_fixed_to_float.sv
// Scoreboard bench for jelly_fixed_to_float: two instances (default format and
// a 4-bit exponent / bias 7 format) share one input stream.
module tb_jelly_fixed_to_float;

  logic        reset;
  logic        clk;
  logic        cke;
  logic [3:0]  s_user;
  logic [23:0] s_fixed;
  logic        s_valid;
  logic        s_ready_a;
  logic        s_ready_b;
  logic [3:0]  m_user_a;
  logic [3:0]  m_user_b;
  logic [22:0] m_float_a;
  logic [20:0] m_float_b;
  logic        m_valid_a;
  logic        m_valid_b;
  logic        m_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [26:0] q_a [$];
  logic [24:0] q_b [$];
  logic [26:0] e_a;
  logic [24:0] e_b;

  logic        cke_toggle = 1'b0;
  logic        skip_chk   = 1'b0;
  logic [3:0]  tag_n      = 4'h0;

  // input, expected default-format output, expected 4-bit-exponent output
  logic [23:0] vec_fixed [13] = '{24'h000100, 24'hFFFE80, 24'h000001, 24'h800000,
                                  24'h000000, 24'h7FFFFF, 24'h00FF00, 24'h010000,
                                  24'h020000, 24'hFFFFFE, 24'hFFFFFF, 24'h000003,
                                  24'h000200};
  logic [22:0] vec_a     [13] = '{23'h1F0000, 23'h5F8000, 23'h170000, 23'h6E0000,
                                  23'h000000, 23'h2DFFFF, 23'h26FE00, 23'h270000,
                                  23'h280000, 23'h580000, 23'h570000, 23'h188000,
                                  23'h200000};
  logic [20:0] vec_b     [13] = '{21'h070000, 21'h178000, 21'h000000, 21'h1FFFFF,
                                  21'h000000, 21'h0FFFFF, 21'h0EFE00, 21'h0F0000,
                                  21'h0FFFFF, 21'h100000, 21'h000000, 21'h008000,
                                  21'h080000};

  jelly_fixed_to_float #(
    .USER_WIDTH(4)
  ) u_dut_a (
    .reset(reset), .clk(clk), .cke(cke),
    .s_user(s_user), .s_fixed(s_fixed), .s_valid(s_valid), .s_ready(s_ready_a),
    .m_user(m_user_a), .m_float(m_float_a), .m_valid(m_valid_a), .m_ready(m_ready)
  );

  jelly_fixed_to_float #(
    .USER_WIDTH(4),
    .M_FLOAT_EXP_WIDTH(4),
    .M_FLOAT_EXP_OFFSET(7)
  ) u_dut_b (
    .reset(reset), .clk(clk), .cke(cke),
    .s_user(s_user), .s_fixed(s_fixed), .s_valid(s_valid), .s_ready(s_ready_b),
    .m_user(m_user_b), .m_float(m_float_b), .m_valid(m_valid_b), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, got, req, $time);
    end
  endtask

  // clock enable: constant high, or toggling every cycle when requested
  initial begin
    cke = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cke = cke_toggle ? ~cke : 1'b1;
    end
  end

  // offer one vector; expected results are queued at the cycle it is accepted
  task automatic send(input int idx);
    bit done;
    done    = 1'b0;
    s_fixed = vec_fixed[idx];
    s_user  = tag_n;
    s_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (s_ready_a) begin
        q_a.push_back({tag_n, vec_a[idx]});
        q_b.push_back({tag_n, vec_b[idx]});
        $display("send idx=%0d user=%h fixed=%h", idx, tag_n, vec_fixed[idx]);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    tag_n   = tag_n + 4'h1;
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send(i);
      s_valid = (i != last);
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 200; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(negedge clk);
    end
    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // monitor: pop and compare on every output transfer
  always @(negedge clk) begin
    if (!reset && cke && m_ready && m_valid_a) begin
      if (q_a.size() == 0) begin
        check("unexpected_out_a", 32'd1, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        $display("recv A user=%h float=%h", m_user_a, m_float_a);
        check("float_a", 32'(m_float_a), 32'(e_a[22:0]));
        check("user_a", 32'(m_user_a), 32'(e_a[26:23]));
      end
    end
    if (!reset && cke && m_ready && m_valid_b) begin
      if (q_b.size() == 0) begin
        check("unexpected_out_b", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        $display("recv B user=%h float=%h", m_user_b, m_float_b);
        check("float_b", 32'(m_float_b), 32'(e_b[20:0]));
        check("user_b", 32'(m_user_b), 32'(e_b[24:21]));
      end
    end
  end

  // stall checker: a presented output that was not taken must be held
  logic        hold_prev = 1'b0;
  logic [22:0] prev_float;
  logic [3:0]  prev_user;
  always @(negedge clk) begin
    if (skip_chk || reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(m_valid_a), 32'd1);
        check("hold_float", 32'(m_float_a), 32'(prev_float));
        check("hold_user", 32'(m_user_a), 32'(prev_user));
      end
      if (m_valid_a && !m_ready) check("stall_s_ready", 32'(s_ready_a), 32'd0);
      if (!cke) check("cke_s_ready", 32'(s_ready_a), 32'd0);
      hold_prev  = m_valid_a && !(m_ready && cke);
      prev_float = m_float_a;
      prev_user  = m_user_a;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset   = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b0;
    s_fixed = '0;
    s_user  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", 32'(m_valid_a), 32'd0);
    check("rst_valid_b", 32'(m_valid_b), 32'd0);
    check("rst_float_a", 32'(m_float_a), 32'd0);
    check("rst_user_a", 32'(m_user_a), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single sample latency
    send(0);
    lat = 0;
    while (!m_valid_a && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_1p0", lat, 3);
    drain();

    // five-sample stream, outputs must be back-to-back
    fork
      send_range(1, 5);
      begin
        for (int i = 0; i < 20 && !m_valid_a; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          check("b2b_valid", 32'(m_valid_a), 32'd1);
          @(negedge clk);
        end
      end
    join
    drain();

    // full table including exponent boundaries
    send_range(0, 12);
    drain();

    // backpressure: m_ready low for 5 cycles mid-stream
    fork
      send_range(0, 12);
      begin
        repeat (6) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // clock enable toggling every other cycle
    cke_toggle = 1'b1;
    send_range(1, 5);
    drain();
    cke_toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset with three samples in flight
    m_ready = 1'b0;
    send_range(1, 3);
    for (int i = 0; i < 20 && !m_valid_a; i++) @(negedge clk);
    @(posedge clk);
    #1;
    skip_chk = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid_a", 32'(m_valid_a), 32'd0);
    check("midrst_valid_b", 32'(m_valid_b), 32'd0);
    check("midrst_float_a", 32'(m_float_a), 32'd0);
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    m_ready  = 1'b1;
    skip_chk = 1'b0;
    @(posedge clk);
    #1;
    send(12);
    lat = 0;
    while (!m_valid_a && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_after_reset", lat, 3);
    drain();

    check("final_q_a", q_a.size(), 0);
    check("final_q_b", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
